// File: rtl/decimal_char_emitter.sv
// Binary-to-ASCII decimal streamer: sequential double-dabble, then one byte per clock.
// Optional signed input mode: define DECIMAL_CHAR_EMITTER_SIGNED_EN.
module decimal_char_emitter #(
  parameter int          WIDTH      = 16,
  parameter int          DIGITS     = 5,
  parameter logic [7:0]  TERMINATOR = 8'h0A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             start,
  output logic [7:0]       character,
  output logic             enable_character,
  output logic             busy,
  output logic             done
);

  localparam int BW = 4 * DIGITS;
  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, EMIT} state_t;
  typedef enum logic [1:0] {P_SIGN, P_DIGIT, P_TERM, P_FIN} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [7:0]       char_q, char_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef DECIMAL_CHAR_EMITTER_SIGNED_EN
  logic             neg_q, neg_d;
`endif

  logic [BW-1:0]    adj;
  logic [BW-1:0]    bcd_step;
  logic [PW-1:0]    ptr_init;
  logic [3:0]       cur;

  assign character        = char_q;
  assign enable_character = en_q;
  assign busy             = busy_q;
  assign done             = done_q;

  // One double-dabble step and the leading-digit search on its result
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_step = {adj[BW-2:0], shreg_q[WIDTH-1]};
    ptr_init = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_step[4*i +: 4] != 4'd0)
        ptr_init = PW'(i);
    end
  end

  // Select the digit under the pointer
  always_comb begin
    cur = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (PW'(i) == ptr_q)
        cur = bcd_q[4*i +: 4];
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    char_d  = char_q;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef DECIMAL_CHAR_EMITTER_SIGNED_EN
    neg_d   = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef DECIMAL_CHAR_EMITTER_SIGNED_EN
          // Modular negation yields 2^(WIDTH-1) exactly for the most negative value
          neg_d   = value[WIDTH-1];
          shreg_d = value[WIDTH-1] ? (~value + 1'b1) : value;
`else
          shreg_d = value;
`endif
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d   = bcd_step;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = EMIT;
          ptr_d   = ptr_init;
`ifdef DECIMAL_CHAR_EMITTER_SIGNED_EN
          phase_d = neg_q ? P_SIGN : P_DIGIT;
`else
          phase_d = P_DIGIT;
`endif
        end
      end
      EMIT: begin
        unique case (phase_q)
          P_DIGIT: begin
            char_d = 8'h30 + {4'h0, cur};
            en_d   = 1'b1;
            if (ptr_q == '0)
              phase_d = P_TERM;
            else
              ptr_d = ptr_q - 1'b1;
          end
          P_TERM: begin
            char_d  = TERMINATOR;
            en_d    = 1'b1;
            phase_d = P_FIN;
          end
          P_FIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
          default: begin
`ifdef DECIMAL_CHAR_EMITTER_SIGNED_EN
            char_d = 8'h2D;
            en_d   = 1'b1;
`endif
            phase_d = P_DIGIT;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= P_DIGIT;
      shreg_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      char_q  <= 8'h00;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DECIMAL_CHAR_EMITTER_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      char_q  <= char_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DECIMAL_CHAR_EMITTER_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_decimal_char_emitter.sv
// Self-checking bench for decimal_char_emitter: vector table, corner sequences,
// and random values compared against a $sformatf-based decimal model.
module tb_decimal_char_emitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = '0;
  logic [7:0]  character;
  logic        enable_character;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  byte unsigned got_q[$];
  int fe, de, nd;
  bit bok;

  typedef struct {
    logic [15:0] v;
    string       su;
    string       ss;
  } vec_t;

  vec_t tbl[8];

  decimal_char_emitter dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .start(start),
    .character(character),
    .enable_character(enable_character),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic string model(input logic [15:0] v);
`ifdef DECIMAL_CHAR_EMITTER_SIGNED_EN
    return $sformatf("%0d", $signed(v));
`else
    return $sformatf("%0d", v);
`endif
  endfunction

  function automatic string exp_hex(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++)
      r = {r, $sformatf("%02x ", s[i])};
    r = {r, "0a "};
    return r;
  endfunction

  function automatic string got_hex();
    string r = "";
    foreach (got_q[i])
      r = {r, $sformatf("%02x ", got_q[i])};
    return r;
  endfunction

  task automatic check_str(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got [%s] expected [%s]", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Start one operation and watch it edge by edge (E0 = accept edge)
  task automatic run_op(input logic [15:0] v, input int noise, input bit brk);
    got_q.delete();
    fe = -1; de = -1; nd = 0; bok = 1'b1;
    value = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    value = 16'($urandom);
    if (!busy) bok = 1'b0;
    for (int e = 1; e < 60; e++) begin
      if (noise != 0 && (e == 5 || e == 18)) begin
        start = 1'b1;
        value = v ^ 16'h1234;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (enable_character) begin
        if (fe < 0) fe = e;
        got_q.push_back(character);
      end
      if (done) begin
        nd++;
        if (de < 0) de = e;
      end
      if (de < 0 && !busy) bok = 1'b0;
      if (de >= 0 && busy) bok = 1'b0;
      if (de >= 0 && (brk || e > de + 3)) break;
    end
  endtask

  task automatic verify(input string name, input logic [15:0] v,
                        input string s, input int noise, input bit brk);
    run_op(v, noise, brk);
    check_str({name, " stream"}, got_hex(), exp_hex(s));
    check_int({name, " first_edge"}, fe, 17);
    check_int({name, " done_edge"}, de, 17 + s.len() + 1);
    check_int({name, " done_count"}, nd, 1);
    check_int({name, " busy_window"}, int'(bok), 1);
  endtask

  initial begin
    tbl[0] = '{16'd1021,  "1021",  "1021"};
    tbl[1] = '{16'd65535, "65535", "-1"};
    tbl[2] = '{16'h8000,  "32768", "-32768"};
    tbl[3] = '{16'd0,     "0",     "0"};
    tbl[4] = '{16'd5933,  "5933",  "5933"};
    tbl[5] = '{16'd10,    "10",    "10"};
    tbl[6] = '{16'd32767, "32767", "32767"};
    tbl[7] = '{16'd40000, "40000", "-25536"};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_int("reset character", int'(character), 0);
    check_int("reset enable", int'(enable_character), 0);
    check_int("reset busy", int'(busy), 0);
    check_int("reset done", int'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
`ifdef DECIMAL_CHAR_EMITTER_SIGNED_EN
      verify($sformatf("tbl%0d", i), tbl[i].v, tbl[i].ss, 0, 1'b0);
`else
      verify($sformatf("tbl%0d", i), tbl[i].v, tbl[i].su, 0, 1'b0);
`endif
    end

    verify("b2b first", 16'd5933, model(16'd5933), 0, 1'b1);
    verify("b2b second", 16'd0, "0", 0, 1'b0);

    verify("ignored_start", 16'd1021, "1021", 1, 1'b0);

    value = 16'd1021;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (17) begin
      @(posedge clk); #1;
    end
    check_int("abort first byte en", int'(enable_character), 1);
    check_int("abort first byte", int'(character), 8'h31);
    rst = 1'b1;
    @(posedge clk); #1;
    check_int("abort character", int'(character), 0);
    check_int("abort enable", int'(enable_character), 0);
    check_int("abort busy", int'(busy), 0);
    check_int("abort done", int'(done), 0);
    rst = 1'b0;
    begin
      int quiet = 0;
      repeat (30) begin
        @(posedge clk); #1;
        if (enable_character || done || busy) quiet++;
      end
      check_int("abort quiet", quiet, 0);
    end
    verify("after_abort", 16'd1021, "1021", 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [15:0] rv;
      rv = 16'($urandom_range(0, 65535));
      verify($sformatf("rand %0d", rv), rv, model(rv), 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
